awg_cmd_ctrl: RTL

Framed command controller that sits between the UART receiver and the waveform generator in the AWG. It parses 5-byte command frames from the received byte stream, validates each frame with an XOR checksum and an inter-byte timeout, and stages the waveform parameters in shadow registers. A commit command transfers them atomically to the active outputs that drive the generator, and error status is reported for each rejected frame.

---
 rtl/awg_pkg.sv | 35 +++
 rtl/awg_cmd_ctrl_if.sv | 25 ++
 rtl/awg_byte_timer.sv | 29 ++
 rtl/awg_cmd_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/awg_pkg.sv
// Shared constants, reset defaults and parser state encoding for the AWG command controller.
package awg_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] CMD_TYPE   = 8'h01;
  localparam logic [7:0] CMD_FREQ   = 8'h02;
  localparam logic [7:0] CMD_AMP    = 8'h03;
  localparam logic [7:0] CMD_OFS    = 8'h04;
  localparam logic [7:0] CMD_COMMIT = 8'h05;

  localparam logic [1:0]  DEF_TYPE = 2'd0;
  localparam logic [15:0] DEF_FREQ = 16'd0;
  localparam logic [9:0]  DEF_AMP  = 10'd512;
  localparam logic [9:0]  DEF_OFS  = 10'd512;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_DHI  = 3'd2,
    S_DLO  = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  // True when the command code is known and its payload fits the target register.
  function automatic logic cmd_in_range(input logic [7:0] cmd, input logic [15:0] d);
    case (cmd)
      CMD_TYPE:         cmd_in_range = (d[15:2] == 14'd0);
      CMD_FREQ:         cmd_in_range = 1'b1;
      CMD_AMP, CMD_OFS: cmd_in_range = (d[15:10] == 6'd0);
      CMD_COMMIT:       cmd_in_range = 1'b1;
      default:          cmd_in_range = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/awg_cmd_ctrl_if.sv
// Byte-stream input and waveform-parameter outputs of the command controller.
interface awg_cmd_if;
  logic [7:0]  uart_data;
  logic        data_valid;
  logic [1:0]  waveform_type;
  logic [15:0] frequency;
  logic [9:0]  amplitude;
  logic [9:0]  dc_offset;
  logic        cfg_update;
  logic        cmd_ok;
  logic        cmd_err;
  logic [7:0]  err_count;

  modport master (
    output uart_data, data_valid,
    input  waveform_type, frequency, amplitude, dc_offset,
    input  cfg_update, cmd_ok, cmd_err, err_count
  );

  modport slave (
    input  uart_data, data_valid,
    output waveform_type, frequency, amplitude, dc_offset,
    output cfg_update, cmd_ok, cmd_err, err_count
  );
endinterface

// File: rtl/awg_byte_timer.sv
// Inter-byte idle counter: restarts on every byte, runs only inside a frame.
module awg_byte_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_clear || !i_enable)
      r_cnt <= '0;
    else if (r_cnt != LAST)
      r_cnt <= r_cnt + 1'b1;
  end

  // A byte arriving in the expiry cycle wins, so clear masks the expire.
  assign o_expire = i_enable && !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/awg_cmd_ctrl.sv
// Framed command parser with checksum/timeout validation, shadow staging and atomic commit.
module awg_cmd_ctrl
  import awg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic     clk,
  input  logic     rst_n,
  awg_cmd_if.slave bus
);

  state_t      r_state, w_next;
  logic [7:0]  r_cmd, r_dhi, r_dlo;
  logic [1:0]  r_sh_type, r_act_type;
  logic [15:0] r_sh_freq, r_act_freq;
  logic [9:0]  r_sh_amp,  r_act_amp;
  logic [9:0]  r_sh_ofs,  r_act_ofs;
  logic        r_cfg_update, r_cmd_ok, r_cmd_err;
  logic [7:0]  r_err_count;

  logic        w_expire;
  logic        w_decide;
  logic        w_frame_good;
  logic        w_accept;
  logic        w_reject;
  logic [15:0] w_data;

  awg_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (bus.data_valid),
    .i_enable (r_state != S_IDLE),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_decide     = 1'b0;
    w_data       = {r_dhi, r_dlo};
    w_frame_good = (bus.uart_data == (r_cmd ^ r_dhi ^ r_dlo)) && cmd_in_range(r_cmd, w_data);
    case (r_state)
      S_IDLE: if (bus.data_valid && bus.uart_data == SYNC_BYTE) w_next = S_CMD;
      S_CMD:  if (bus.data_valid) w_next = S_DHI;
      S_DHI:  if (bus.data_valid) w_next = S_DLO;
      S_DLO:  if (bus.data_valid) w_next = S_CHK;
      S_CHK: begin
        if (bus.data_valid) begin
          w_next   = S_IDLE;
          w_decide = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_expire)
      w_next = S_IDLE;
  end

  assign w_accept = w_decide && w_frame_good;
  assign w_reject = (w_decide && !w_frame_good) || w_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= '0;
      r_dhi <= '0;
      r_dlo <= '0;
    end else if (bus.data_valid) begin
      if (r_state == S_CMD) r_cmd <= bus.uart_data;
      if (r_state == S_DHI) r_dhi <= bus.uart_data;
      if (r_state == S_DLO) r_dlo <= bus.uart_data;
    end
  end

  // Commit copies the pre-edge shadow contents, so all four outputs change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_type    <= DEF_TYPE;
      r_sh_freq    <= DEF_FREQ;
      r_sh_amp     <= DEF_AMP;
      r_sh_ofs     <= DEF_OFS;
      r_act_type   <= DEF_TYPE;
      r_act_freq   <= DEF_FREQ;
      r_act_amp    <= DEF_AMP;
      r_act_ofs    <= DEF_OFS;
      r_cfg_update <= 1'b0;
    end else begin
      r_cfg_update <= 1'b0;
      if (w_accept) begin
        case (r_cmd)
          CMD_TYPE: r_sh_type <= w_data[1:0];
          CMD_FREQ: r_sh_freq <= w_data;
          CMD_AMP:  r_sh_amp  <= w_data[9:0];
          CMD_OFS:  r_sh_ofs  <= w_data[9:0];
          CMD_COMMIT: begin
            r_act_type   <= r_sh_type;
            r_act_freq   <= r_sh_freq;
            r_act_amp    <= r_sh_amp;
            r_act_ofs    <= r_sh_ofs;
            r_cfg_update <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_ok    <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_cmd_ok  <= w_accept;
      r_cmd_err <= w_reject;
      if (w_reject && r_err_count != 8'hFF)
        r_err_count <= r_err_count + 8'd1;
    end
  end

  assign bus.waveform_type = r_act_type;
  assign bus.frequency     = r_act_freq;
  assign bus.amplitude     = r_act_amp;
  assign bus.dc_offset     = r_act_ofs;
  assign bus.cfg_update    = r_cfg_update;
  assign bus.cmd_ok        = r_cmd_ok;
  assign bus.cmd_err       = r_cmd_err;
  assign bus.err_count     = r_err_count;

endmodule
